// File: rtl/branch_ctrl.sv
// Branch-resolution controller: resolves taken branches, redirects fetch, holds a flush window.
// Optional saturating statistics counters are compiled in with BRANCH_STATS_EN.
module branch_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned STAT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              br_valid,
   input  logic [3:0]        branch_type,
   input  logic              ALU_zero_flag,
   input  logic              ALU_neg_flag,
   input  logic [31:0]       pc_ex,
   input  logic [31:0]       imm,
   input  logic              fetch_stall,
   input  logic              stat_clr,
   output logic              redirect,
   output logic [31:0]       redirect_pc,
   output logic              flush,
   output logic              busy,
   output logic [STAT_W-1:0] br_count,
   output logic [STAT_W-1:0] taken_count
);

   typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] pc_q, pc_d;
   logic        tk;

   always_comb begin
      tk = 1'b0;
      case (branch_type)
         4'd1:    tk = ALU_zero_flag;
         4'd2:    tk = !ALU_zero_flag;
         4'd3:    tk = ALU_neg_flag;
         4'd4:    tk = !ALU_neg_flag && !ALU_zero_flag;
         4'd5:    tk = !ALU_neg_flag;
         4'd6:    tk = 1'b1;
         default: tk = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      case (state_q)
         StIdle: begin
            if (br_valid && tk) begin
               pc_d    = pc_ex + imm;
               cnt_d   = 4'(FLUSH_CYCLES);
               state_d = StRedirect;
            end
         end
         StRedirect: begin
            if (!fetch_stall) state_d = StFlush;
         end
         StFlush: begin
            if (!fetch_stall) begin
               cnt_d = cnt_q - 4'd1;
               // <= guards against an illegal zero load hanging the FSM
               if (cnt_q <= 4'd1) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         pc_q    <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
      end
   end

   assign redirect    = (state_q == StRedirect);
   assign flush       = (state_q != StIdle);
   assign busy        = (state_q != StIdle);
   assign redirect_pc = pc_q;

`ifdef BRANCH_STATS_EN
   logic [STAT_W-1:0] br_q, tk_q;
   logic              count_en;

   assign count_en = (state_q == StIdle) && br_valid &&
                     (branch_type >= 4'd1) && (branch_type <= 4'd6);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_q <= '0;
         tk_q <= '0;
      end else if (stat_clr) begin
         br_q <= '0;
         tk_q <= '0;
      end else if (count_en) begin
         if (br_q != '1) br_q <= br_q + 1'b1;
         if (tk && (tk_q != '1)) tk_q <= tk_q + 1'b1;
      end
   end

   assign br_count    = br_q;
   assign taken_count = tk_q;
`else
   logic unused_stat;
   assign unused_stat = stat_clr;
   assign br_count    = '0;
   assign taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus random traffic vs. a cycle model.
module tb_branch_ctrl;
   localparam int unsigned FC   = 2;
   localparam int unsigned SW   = 4;
   localparam int          MAXV = (1 << SW) - 1;
`ifdef BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          br_valid = 1'b0;
   logic [3:0]    branch_type = 4'd0;
   logic          zf = 1'b0;
   logic          nf = 1'b0;
   logic [31:0]   pc_ex = 32'h0;
   logic [31:0]   imm = 32'h0;
   logic          fetch_stall = 1'b0;
   logic          stat_clr = 1'b0;
   logic          redirect, flush, busy;
   logic [31:0]   redirect_pc;
   logic [SW-1:0] br_count, taken_count;

   branch_ctrl #(.FLUSH_CYCLES(FC), .STAT_W(SW)) dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .branch_type(branch_type),
      .ALU_zero_flag(zf), .ALU_neg_flag(nf), .pc_ex(pc_ex), .imm(imm),
      .fetch_stall(fetch_stall), .stat_clr(stat_clr), .redirect(redirect),
      .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
      .br_count(br_count), .taken_count(taken_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: a pending redirect flag plus the number of unstalled flush cycles still owed
   bit          m_redir;
   int          m_left;
   logic [31:0] m_pc;
   int          m_br, m_tk;

   function automatic bit cond(input logic [3:0] t, input logic z, input logic n);
      case (t)
         4'd1:    return z;
         4'd2:    return !z;
         4'd3:    return n;
         4'd4:    return !n && !z;
         4'd5:    return !n;
         4'd6:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_redir = 1'b0; m_left = 0; m_pc = 32'h0; m_br = 0; m_tk = 0;
   endtask

   task automatic model_clock();
      bit idle, t;
      idle = !m_redir && (m_left == 0);
      t    = cond(branch_type, zf, nf);
      if (STATS) begin
         if (stat_clr) begin
            m_br = 0; m_tk = 0;
         end else if (idle && br_valid && branch_type >= 1 && branch_type <= 6) begin
            if (m_br < MAXV) m_br++;
            if (t && m_tk < MAXV) m_tk++;
         end
      end
      if (idle) begin
         if (br_valid && t) begin
            m_pc = pc_ex + imm; m_redir = 1'b1; m_left = FC;
         end
      end else if (m_redir) begin
         if (!fetch_stall) m_redir = 1'b0;
      end else if (!fetch_stall) begin
         m_left--;
      end
   endtask

   task automatic check_all(input string ctx);
      bit act;
      act = m_redir || (m_left > 0);
      check({ctx, ".redirect"}, {31'b0, redirect}, {31'b0, m_redir});
      check({ctx, ".flush"}, {31'b0, flush}, {31'b0, act});
      check({ctx, ".busy"}, {31'b0, busy}, {31'b0, act});
      check({ctx, ".redirect_pc"}, redirect_pc, m_pc);
      check({ctx, ".br_count"}, 32'(br_count), 32'(m_br));
      check({ctx, ".taken_count"}, 32'(taken_count), 32'(m_tk));
   endtask

   task automatic step(input string ctx);
      @(posedge clk);
      model_clock();
      #1;
      check_all(ctx);
   endtask

   task automatic set_br(input logic v, input logic [3:0] t, input logic z, input logic n,
                         input logic [31:0] p, input logic [31:0] i);
      br_valid = v; branch_type = t; zf = z; nf = n; pc_ex = p; imm = i;
   endtask

   initial begin
      model_reset();
      #2;
      check_all("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      check_all("post_reset");

      // BEQ taken: one redirect cycle, FC flush cycles, then idle
      set_br(1'b1, 4'd1, 1'b1, 1'b0, 32'h100, 32'h20);
      step("beq_accept");
      check("beq.target", redirect_pc, 32'h120);
      check("beq.redirect", {31'b0, redirect}, 32'd1);
      br_valid = 1'b0;
      for (int k = 0; k < 4; k++) step("beq_seq");
      check("beq.idle", {31'b0, busy}, 32'd0);

      // Not-taken BNE and GT
      set_br(1'b1, 4'd2, 1'b1, 1'b0, 32'h200, 32'h8);
      step("bne_nt");
      set_br(1'b1, 4'd4, 1'b1, 1'b0, 32'h200, 32'h8);
      step("gt_nt");
      br_valid = 1'b0;
      step("nt_after");
      check("nt.redirect", {31'b0, redirect}, 32'd0);

      // JAL with 3 stalled REDIRECT cycles, then a 1-cycle stall in FLUSH
      set_br(1'b1, 4'd6, 1'b0, 1'b0, 32'h4000, 32'h40);
      step("jal_accept");
      br_valid = 1'b0; fetch_stall = 1'b1;
      for (int k = 0; k < 3; k++) step("jal_stall");
      check("jal.hold_pc", redirect_pc, 32'h4040);
      fetch_stall = 1'b0;
      step("jal_leave");
      fetch_stall = 1'b1;
      step("flush_stall");
      fetch_stall = 1'b0;
      for (int k = 0; k < 3; k++) step("flush_tail");

      // Target wrap-around via LT, then a taken JAL during FLUSH is ignored
      set_br(1'b1, 4'd3, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h20);
      step("lt_wrap");
      check("wrap.target", redirect_pc, 32'h10);
      br_valid = 1'b0;
      step("wrap_redir");
      set_br(1'b1, 4'd6, 1'b0, 1'b0, 32'h8000, 32'h4);
      step("ignored_jal");
      br_valid = 1'b0;
      for (int k = 0; k < 2; k++) step("wrap_tail");
      check("ignored.pc", redirect_pc, 32'h10);

      // Asynchronous reset between edges while in FLUSH
      set_br(1'b1, 4'd6, 1'b0, 1'b0, 32'h1234, 32'h10);
      step("ar_accept");
      br_valid = 1'b0;
      step("ar_flush");
      #3 rst = 1'b1;
      #1;
      model_reset();
      check("async.flush", {31'b0, flush}, 32'd0);
      check("async.busy", {31'b0, busy}, 32'd0);
      check("async.pc", redirect_pc, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // 20 back-to-back JALs: counters saturate
      set_br(1'b1, 4'd6, 1'b0, 1'b0, 32'h10, 32'h10);
      for (int k = 0; k < 20 * (FC + 2); k++) step("sat");
      br_valid = 1'b0;
      step("sat_end");
      if (STATS) check("sat.br", 32'(br_count), MAXV);

      // stat_clr together with an accepted branch
      set_br(1'b1, 4'd6, 1'b0, 1'b0, 32'h20, 32'h20);
      stat_clr = 1'b1;
      step("clr");
      stat_clr = 1'b0; br_valid = 1'b0;
      check("clr.br", 32'(br_count), 32'd0);
      for (int k = 0; k < 4; k++) step("clr_tail");

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         set_br(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
         fetch_stall = ($urandom % 4) == 0;
         stat_clr    = ($urandom % 25) == 0;
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Sequential branch-resolution controller between the execute stage and fetch. It samples the branch condition from the ALU flags and computes the taken target. It then issues a PC redirect to fetch and holds a pipeline-flush window for the squashed younger instructions. Backpressure from a stalled fetch is respected. Optional saturating branch statistics counters can be compiled in.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles `flush` stays high after the redirect cycle; legal range 1–15.
- STAT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- br_valid  in  1  a branch or jump is in execute this cycle
- branch_type  in  4  0 none, 1 EQ, 2 NE, 3 LT, 4 GT, 5 GE, 6 JAL (unconditional), 7–15 none
- ALU_zero_flag  in  1  ALU result zero
- ALU_neg_flag  in  1  ALU result negative
- pc_ex  in  32  PC of the execute-stage instruction
- imm  in  32  sign-extended branch offset
- fetch_stall  in  1  fetch cannot accept a redirect or advance
- stat_clr  in  1  synchronous clear of statistics
- redirect  out  1  fetch must load `redirect_pc`
- redirect_pc  out  32  taken target
- flush  out  1  squash IF/ID contents
- busy  out  1  controller not in IDLE
- br_count  out  STAT_W  resolved branches
- taken_count  out  STAT_W  taken branches

One clock, `clk`. Reset `rst` is asynchronous and active-high.

## Operation
- Taken condition `tk`:
  - EQ = zero
  - NE = !zero
  - LT = neg
  - GT = !neg & !zero
  - GE = !neg
  - JAL = 1
  - any other `branch_type` = 0
- Target = pc_ex + imm, modulo 2^32, with no overflow flag.
- States: IDLE, REDIRECT, FLUSH.
- IDLE:
  - `br_valid & tk` registers the target into `redirect_pc`, loads the flush counter with FLUSH_CYCLES, and moves to REDIRECT.
  - `br_valid & !tk` stays in IDLE with no output activity.
- REDIRECT:
  - `redirect` = 1 and `flush` = 1.
  - Leaves for FLUSH on the first cycle with `fetch_stall` = 0; the redirect counts as consumed in that cycle.
  - While `fetch_stall` = 1, stays in REDIRECT with `redirect_pc` held.
- FLUSH:
  - `flush` = 1 and `redirect` = 0.
  - The counter decrements only when `fetch_stall` = 0.
  - When the counter goes 1→0, the next state is IDLE.
- `br_valid` is ignored in REDIRECT and FLUSH (squashed instructions). It is not counted in statistics.
- `busy` = (state != IDLE).
- Reset values:
  - state IDLE
  - `redirect` 0, `flush` 0, `busy` 0
  - `redirect_pc` 32'h0
  - flush counter 0
  - `br_count` 0, `taken_count` 0
- Reset asserted mid-operation immediately forces IDLE and the above values. Any pending redirect is lost.

## Timing
- Cycle N: `br_valid` & `tk` sampled at the rising edge.
- Cycle N+1: `redirect` = 1, `flush` = 1, `redirect_pc` valid.
- With no stall:
  - Cycles N+2 … N+1+FLUSH_CYCLES: `flush` = 1.
  - Cycle N+2+FLUSH_CYCLES: IDLE, and `br_valid` is accepted again.
- Each stalled cycle in REDIRECT or FLUSH extends the sequence by exactly one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `br_count` increments on every IDLE-state cycle with `br_valid` and a `branch_type` in 1–6.
  - `taken_count` increments when that branch is also taken.
  - Both counters saturate at 2^STAT_W−1.
  - `stat_clr` zeroes both counters and takes priority over an increment in the same cycle.
- `BRANCH_STATS_EN` undefined:
  - No counter flops are built.
  - `br_count` and `taken_count` are tied to 0.
  - `stat_clr` is ignored.

## Test plan
- Reset, then a BEQ:
  - Stimulus: `rst` pulse; then `br_valid`=1, `branch_type`=1, zero=1, `pc_ex`=32'h100, `imm`=32'h20; FLUSH_CYCLES=2.
  - Response: `redirect`=1 with `redirect_pc`=32'h120 for one cycle, then `flush` high for 2 more cycles, then `busy`=0.
- Not-taken branches:
  - Stimulus: BNE with zero=1; then GT with neg=0, zero=1.
  - Response: `redirect`=0 and `flush`=0 throughout; with stats enabled, `br_count`=2 and `taken_count`=0.
- Stall during REDIRECT and FLUSH:
  - Stimulus: JAL with `fetch_stall`=1 for 3 cycles during REDIRECT.
  - Response: `redirect` stays high for 4 cycles with `redirect_pc` constant.
  - Stimulus: a 1-cycle stall during FLUSH.
  - Response: the flush window extends to 3 cycles.
- Wrap-around and ignored branches:
  - Stimulus: `pc_ex`=32'hFFFF_FFF0, `imm`=32'h20, LT with neg=1.
  - Response: `redirect_pc`=32'h10.
  - Stimulus: a second `br_valid` with a taken condition during FLUSH.
  - Response: ignored, with no second redirect and no count.
- Asynchronous reset mid-FLUSH:
  - Stimulus: assert `rst` between clock edges while in FLUSH.
  - Response: `flush`, `busy`, and `redirect_pc` go to 0 immediately, before the next clock edge.
- Statistics saturation and clear (`BRANCH_STATS_EN`, STAT_W=4):
  - Stimulus: 20 taken JALs.
  - Response: both counters hold at 15.
  - Stimulus: `stat_clr` asserted together with a branch.
  - Response: both counters become 0.
